// File: rtl/pipe_mem_stage.sv
// MEM stage: issues byte/half/word loads and stores to a req/ack data memory,
// stalls upstream while an access is outstanding, and feeds MEM/WB.
module pipe_mem_stage #(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        mwreg,
    input  logic        mm2reg,
    input  logic        mwmem,
    input  logic [1:0]  msize,
    input  logic        msign,
    input  logic [31:0] malu,
    input  logic [31:0] mb,
    input  logic [4:0]  mrn,
    output logic        ow_wreg,
    output logic        ow_m2reg,
    output logic [4:0]  ow_rn,
    output logic [31:0] ow_alu,
    output logic [31:0] mmo,
    output logic        mstall,
    output logic        dm_req,
    output logic        dm_we,
    output logic [31:0] dm_addr,
    output logic [3:0]  dm_be,
    output logic [31:0] dm_wdata,
    input  logic        dm_ack,
    input  logic [31:0] dm_rdata,
    output logic        maddr_err,
    output logic        mbus_err,
    output logic [31:0] mbadvaddr
);
    typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

    state_t      state, state_nx;
    logic [7:0]  cnt;
    logic        abort;
    logic [31:0] rdata_q, bad_q, addr_q, wdata_q;
    logic [3:0]  be_q;
    logic        we_q, sign_q;
    logic [1:0]  size_q, lane_q;

    logic        mem_op, misaligned, timed_out;
    logic [3:0]  st_be;
    logic [31:0] st_wdata, ld_ext;
    logic [7:0]  b_sel;
    logic [15:0] h_sel;

    assign mem_op     = mm2reg | mwmem;
    assign misaligned = ((msize == 2'b01) & malu[0]) | (msize[1] & (malu[1:0] != 2'b00));
    assign timed_out  = (cnt == 8'(TIMEOUT - 1));

    always_comb begin
        st_be    = 4'b1111;
        st_wdata = mb;
        case (msize)
            2'b00: begin
                st_be    = 4'b0001 << malu[1:0];
                st_wdata = {4{mb[7:0]}};
            end
            2'b01: begin
                st_be    = malu[1] ? 4'b1100 : 4'b0011;
                st_wdata = {2{mb[15:0]}};
            end
            default: ;
        endcase
    end

    // Extraction uses the lane/size latched at issue, not the live inputs.
    always_comb begin
        b_sel  = dm_rdata[{lane_q, 3'b000} +: 8];
        h_sel  = lane_q[1] ? dm_rdata[31:16] : dm_rdata[15:0];
        ld_ext = dm_rdata;
        case (size_q)
            2'b00:   ld_ext = {{24{sign_q & b_sel[7]}}, b_sel};
            2'b01:   ld_ext = {{16{sign_q & h_sel[15]}}, h_sel};
            default: ;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= '0;
            abort   <= 1'b0;
            rdata_q <= '0;
            bad_q   <= '0;
            addr_q  <= '0;
            be_q    <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
            size_q  <= '0;
            sign_q  <= 1'b0;
            lane_q  <= '0;
        end else begin
            state <= state_nx;
            case (state)
                IDLE: if (mem_op) begin
                    if (misaligned) begin
                        bad_q <= malu;
                    end else begin
                        addr_q  <= {malu[31:2], 2'b00};
                        lane_q  <= malu[1:0];
                        be_q    <= mm2reg ? 4'b1111 : st_be;
                        wdata_q <= st_wdata;
                        we_q    <= ~mm2reg;
                        size_q  <= msize;
                        sign_q  <= msign;
                        cnt     <= '0;
                        abort   <= 1'b0;
                    end
                end
                REQ: begin
                    if (dm_ack) begin
                        if (!we_q) rdata_q <= ld_ext;
                    end else if (timed_out) begin
                        abort <= 1'b1;
                        bad_q <= {addr_q[31:2], lane_q};
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_nx  = state;
        ow_wreg   = mwreg;
        mmo       = '0;
        mstall    = 1'b0;
        maddr_err = 1'b0;
        mbus_err  = 1'b0;
        case (state)
            IDLE: if (mem_op) begin
                ow_wreg = 1'b0;
                if (misaligned) begin
                    maddr_err = 1'b1;
                end else begin
                    mstall   = 1'b1;
                    state_nx = REQ;
                end
            end
            REQ: begin
                ow_wreg = 1'b0;
                mstall  = 1'b1;
                if (dm_ack || timed_out) state_nx = DONE;
            end
            DONE: begin
                mmo      = mm2reg ? rdata_q : '0;
                ow_wreg  = mwreg & ~abort;
                mbus_err = abort;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    assign dm_req    = (state == REQ);
    assign dm_we     = we_q;
    assign dm_addr   = addr_q;
    assign dm_be     = be_q;
    assign dm_wdata  = wdata_q;
    assign mbadvaddr = bad_q;
    assign ow_m2reg  = mm2reg;
    assign ow_rn     = mrn;
    assign ow_alu    = malu;
endmodule

// File: tb/tb_pipe_mem_stage.sv
// Bench for pipe_mem_stage: transaction-level model checked every cycle,
// plus directed operations with hand-computed results.
module tb_pipe_mem_stage;
    localparam int TO = 4;

    logic        clock = 1'b0, reset = 1'b1;
    logic        mwreg = 0, mm2reg = 0, mwmem = 0, msign = 0;
    logic [1:0]  msize = 0;
    logic [31:0] malu = 0, mb = 0;
    logic [4:0]  mrn = 0;
    logic        ow_wreg, ow_m2reg, mstall, dm_req, dm_we, maddr_err, mbus_err;
    logic [4:0]  ow_rn;
    logic [31:0] ow_alu, mmo, dm_addr, dm_wdata, mbadvaddr;
    logic [3:0]  dm_be;
    logic        dm_ack = 0;
    logic [31:0] dm_rdata = 0;

    pipe_mem_stage #(.TIMEOUT(TO)) dut (
        .clock(clock), .reset(reset), .mwreg(mwreg), .mm2reg(mm2reg), .mwmem(mwmem),
        .msize(msize), .msign(msign), .malu(malu), .mb(mb), .mrn(mrn),
        .ow_wreg(ow_wreg), .ow_m2reg(ow_m2reg), .ow_rn(ow_rn), .ow_alu(ow_alu),
        .mmo(mmo), .mstall(mstall), .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr),
        .dm_be(dm_be), .dm_wdata(dm_wdata), .dm_ack(dm_ack), .dm_rdata(dm_rdata),
        .maddr_err(maddr_err), .mbus_err(mbus_err), .mbadvaddr(mbadvaddr)
    );

    always #5 clock = ~clock;

    int n_chk = 0, n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Transaction-level model: outstanding access, cycles waited, result cycle.
    bit          m_pend, m_fin, m_abort;
    int          m_waited;
    logic [31:0] m_last, m_bad, op_addr;
    logic [1:0]  op_size;
    logic        op_sign, op_load;
    logic [31:0] op_b;

    function automatic bit is_misaligned(input logic [1:0] sz, input logic [31:0] a);
        if (sz == 2'd1) return (a % 2) != 0;
        if (sz >= 2'd2) return (a % 4) != 0;
        return 0;
    endfunction

    function automatic logic [31:0] extract(input logic [31:0] rd, input logic [1:0] sz,
                                            input logic sg, input logic [31:0] a);
        logic [31:0] v;
        case (sz)
            2'd0: begin
                v = (rd >> (8 * (a % 4))) & 32'hFF;
                if (sg && v >= 128) v = v + 32'hFFFFFF00;
            end
            2'd1: begin
                v = (rd >> (16 * ((a % 4) / 2))) & 32'hFFFF;
                if (sg && v >= 32768) v = v + 32'hFFFF0000;
            end
            default: v = rd;
        endcase
        return v;
    endfunction

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            m_pend = 0; m_fin = 0; m_abort = 0; m_waited = 0; m_last = 0; m_bad = 0;
        end else if (m_fin) begin
            m_fin = 0;
        end else if (m_pend) begin
            if (dm_ack) begin
                if (op_load) m_last = extract(dm_rdata, op_size, op_sign, op_addr);
                m_pend = 0; m_fin = 1; m_abort = 0;
            end else if (m_waited + 1 == TO) begin
                m_pend = 0; m_fin = 1; m_abort = 1; m_bad = op_addr;
            end else begin
                m_waited++;
            end
        end else if (mm2reg || mwmem) begin
            if (is_misaligned(msize, malu)) begin
                m_bad = malu;
            end else begin
                m_pend = 1; m_waited = 0;
                op_addr = malu; op_size = msize; op_sign = msign; op_load = mm2reg; op_b = mb;
            end
        end
    end

    always @(negedge clock) begin
        if (!reset) begin
            bit          memop, idle;
            logic [3:0]  ebe;
            logic [31:0] ewd;
            memop = mm2reg || mwmem;
            idle  = !m_pend && !m_fin;
            chk("ow_m2reg", ow_m2reg, mm2reg);
            chk("ow_rn", ow_rn, mrn);
            chk("ow_alu", ow_alu, malu);
            chk("dm_req", dm_req, m_pend);
            chk("mstall", mstall, m_pend || (idle && memop && !is_misaligned(msize, malu)));
            chk("maddr_err", maddr_err, idle && memop && is_misaligned(msize, malu));
            chk("mbus_err", mbus_err, m_fin && m_abort);
            chk("ow_wreg", ow_wreg, m_fin ? (mwreg && !m_abort) : (m_pend || memop) ? 1'b0 : mwreg);
            chk("mmo", mmo, (m_fin && mm2reg) ? m_last : 32'h0);
            chk("mbadvaddr", mbadvaddr, m_bad);
            if (m_pend) begin
                if (op_load || op_size >= 2) begin
                    ebe = 4'hF; ewd = op_b;
                end else if (op_size == 0) begin
                    ebe = 4'(1 << (op_addr % 4)); ewd = (op_b & 32'hFF) * 32'h01010101;
                end else begin
                    ebe = (op_addr % 4 >= 2) ? 4'hC : 4'h3; ewd = (op_b & 32'hFFFF) * 32'h00010001;
                end
                chk("dm_addr", dm_addr, op_addr - (op_addr % 4));
                chk("dm_be", dm_be, ebe);
                chk("dm_we", dm_we, !op_load);
                if (!op_load) chk("dm_wdata", dm_wdata, ewd);
            end
        end
    end

    int          stall_n, req_n;
    logic [31:0] cap_addr, cap_wdata, fin_mmo;
    logic [3:0]  cap_be;
    logic        cap_we, fin_wreg, fin_bus, fin_aerr;

    task automatic run_op(input logic wr, ld, st, input logic [1:0] sz, input logic sg,
                          input logic [31:0] alu, b, input logic [4:0] rn,
                          input int ack_at, input logic [31:0] rd);
        bit got = 0;
        mwreg = wr; mm2reg = ld; mwmem = st; msize = sz; msign = sg;
        malu = alu; mb = b; mrn = rn;
        stall_n = 0; req_n = 0;
        for (int cyc = 0; cyc < 40 && !got; cyc++) begin
            @(negedge clock);
            if (mstall) stall_n++;
            if (dm_req) begin
                if (req_n == 0) begin
                    cap_addr = dm_addr; cap_be = dm_be; cap_wdata = dm_wdata; cap_we = dm_we;
                end
                if (req_n == ack_at) begin dm_ack = 1; dm_rdata = rd; end
                req_n++;
            end
            if (!mstall) begin
                got = 1;
                fin_mmo = mmo; fin_wreg = ow_wreg; fin_bus = mbus_err; fin_aerr = maddr_err;
            end
            @(posedge clock); #1;
            dm_ack = 0;
        end
        if (!got) chk("op_completes", 0, 1);
    endtask

    initial begin
        #12;
        chk("rst_dm_req", dm_req, 0);
        chk("rst_mstall", mstall, 0);
        chk("rst_mbus_err", mbus_err, 0);
        chk("rst_mbadvaddr", mbadvaddr, 0);
        chk("rst_dm_addr", dm_addr, 0);
        chk("rst_dm_be", dm_be, 0);
        @(posedge clock); #1; reset = 0;

        run_op(1, 1, 0, 2'd2, 0, 32'h100, 0, 5'd5, 0, 32'hDEADBEEF);
        chk("lw_stall_n", stall_n, 2);
        chk("lw_req_n", req_n, 1);
        chk("lw_addr", cap_addr, 32'h100);
        chk("lw_be", cap_be, 4'hF);
        chk("lw_mmo", fin_mmo, 32'hDEADBEEF);
        chk("lw_wreg", fin_wreg, 1);

        run_op(1, 1, 0, 2'd0, 1, 32'h103, 0, 5'd6, 0, 32'h80123456);
        chk("lb_mmo", fin_mmo, 32'hFFFFFF80);
        chk("lb_addr", cap_addr, 32'h100);
        run_op(1, 1, 0, 2'd0, 0, 32'h103, 0, 5'd7, 0, 32'h80123456);
        chk("lbu_mmo", fin_mmo, 32'h00000080);

        run_op(1, 1, 0, 2'd1, 1, 32'h102, 0, 5'd8, 2, 32'h80123456);
        chk("lh_mmo", fin_mmo, 32'hFFFF8012);
        chk("lh_stall_n", stall_n, 4);

        run_op(0, 0, 1, 2'd1, 0, 32'h22, 32'h0000ABCD, 5'd0, 0, 0);
        chk("sh_be", cap_be, 4'hC);
        chk("sh_wdata", cap_wdata, 32'hABCDABCD);
        chk("sh_we", cap_we, 1);
        chk("sh_mmo", fin_mmo, 0);
        chk("sh_wreg", fin_wreg, 0);

        run_op(0, 0, 1, 2'd0, 0, 32'h101, 32'h0000005A, 5'd0, 1, 0);
        chk("sb_be", cap_be, 4'h2);
        chk("sb_wdata", cap_wdata, 32'h5A5A5A5A);

        run_op(0, 0, 1, 2'd3, 0, 32'h40, 32'hCAFEF00D, 5'd0, 0, 0);
        chk("sw3_be", cap_be, 4'hF);
        chk("sw3_wdata", cap_wdata, 32'hCAFEF00D);

        run_op(1, 1, 0, 2'd2, 0, 32'h101, 0, 5'd9, 0, 0);
        chk("mis_aerr", fin_aerr, 1);
        chk("mis_req_n", req_n, 0);
        chk("mis_stall_n", stall_n, 0);
        chk("mis_wreg", fin_wreg, 0);
        chk("mis_badvaddr", mbadvaddr, 32'h101);

        run_op(1, 0, 0, 2'd0, 0, 32'h1234, 0, 5'd3, -1, 0);
        chk("alu_wreg", fin_wreg, 1);
        chk("alu_mmo", fin_mmo, 0);
        chk("alu_stall_n", stall_n, 0);

        run_op(1, 1, 0, 2'd2, 0, 32'h300, 0, 5'd4, -1, 0);
        chk("to_req_n", req_n, TO);
        chk("to_bus_err", fin_bus, 1);
        chk("to_wreg", fin_wreg, 0);
        chk("to_badvaddr", mbadvaddr, 32'h300);

        run_op(1, 1, 0, 2'd2, 0, 32'h304, 0, 5'd4, TO - 1, 32'h11223344);
        chk("late_ack_req_n", req_n, TO);
        chk("late_ack_bus_err", fin_bus, 0);
        chk("late_ack_mmo", fin_mmo, 32'h11223344);
        chk("late_ack_wreg", fin_wreg, 1);

        // Reset during the second request cycle, then a stale ack.
        mwreg = 1; mm2reg = 1; mwmem = 0; msize = 2'd2; malu = 32'h200; mrn = 5'd2;
        @(negedge clock); @(negedge clock); @(negedge clock);
        chk("rq_dm_req_before", dm_req, 1);
        #2;
        mwreg = 0; mm2reg = 0; malu = 0; mrn = 0; reset = 1;
        #1;
        chk("rq_dm_req", dm_req, 0);
        chk("rq_mstall", mstall, 0);
        chk("rq_dm_addr", dm_addr, 0);
        chk("rq_dm_be", dm_be, 0);
        chk("rq_mbadvaddr", mbadvaddr, 0);
        chk("rq_ow_wreg", ow_wreg, 0);
        @(posedge clock); #1;
        reset = 0; dm_ack = 1; dm_rdata = 32'h55555555;
        @(negedge clock);
        chk("stale_wreg", ow_wreg, 0);
        @(posedge clock); #1;
        dm_ack = 0;
        @(negedge clock);
        chk("stale_dm_req", dm_req, 0);
        chk("stale_mmo", mmo, 0);
        @(negedge clock);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end
endmodule

// File: doc/pipe_mem_stage.md
# pipe_mem_stage

Memory-access (MEM) stage of the five-stage pipeline. It sits between the EX/MEM pipeline register and the MEM/WB register, and issues byte/halfword/word loads and stores to a variable-latency data memory over a req/ack handshake. It freezes the upstream pipeline with `mstall` while an access is outstanding. It presents the aligned, sign- or zero-extended load result plus the pass-through writeback controls to MEM/WB.

## Interface
- `TIMEOUT`, default 15: the maximum number of cycles `dm_req` may wait for `dm_ack` before the access is aborted. Range 1–255.
- `clock` in 1: single clock; all state updates on its rising edge.
- `reset` in 1: asynchronous, active-high. Clears all state immediately.
- `mwreg` in 1: instruction writes the register file.
- `mm2reg` in 1: instruction is a load; its result comes from memory.
- `mwmem` in 1: instruction is a store.
- `msize` in 2: access size. 00 = byte, 01 = half, 10 = word, 11 = treated as word.
- `msign` in 1: loads only. 1 = sign-extend, 0 = zero-extend.
- `malu` in 32: effective address, or ALU result for non-memory instructions.
- `mb` in 32: store data in the low bits.
- `mrn` in 5: destination register number.
- `ow_wreg`, `ow_m2reg` out 1: writeback controls to MEM/WB.
- `ow_rn` out 5: destination register number to MEM/WB.
- `ow_alu` out 32: `malu` pass-through to MEM/WB.
- `mmo` out 32: load result to MEM/WB.
- `mstall` out 1: freezes the PC, IF/ID, ID/EX and EX/MEM registers.
- `dm_req` out 1, `dm_we` out 1: memory request and write enable.
- `dm_addr` out 32: word address; bits [1:0] are always 00.
- `dm_be` out 4: byte enables.
- `dm_wdata` out 32: store data placed on byte lanes.
- `dm_ack` in 1: memory completion, one-cycle pulse.
- `dm_rdata` in 32: load data, valid while `dm_ack` is high.
- `maddr_err` out 1: misaligned-access pulse.
- `mbus_err` out 1: timeout pulse.
- `mbadvaddr` out 32: last faulting address.

## Operation
- A memory operation is present when `mm2reg | mwmem` is 1. Loads take priority if both are set.
- Misalignment rules:
  - half access with `malu[0]`=1 is misaligned;
  - word access with `malu[1:0]`≠00 is misaligned;
  - byte accesses are never misaligned.
- Store lanes, little-endian:
  - byte: `dm_be` = 0001 << `malu[1:0]`, `dm_wdata` = four copies of `mb[7:0]`;
  - half: `dm_be` = 1100 if `malu[1]` is set, else 0011; `dm_wdata` = two copies of `mb[15:0]`;
  - word: `dm_be` = 1111, `dm_wdata` = `mb`.
- Loads request `dm_be` = 1111. The result is taken from lane `malu[1:0]` (byte) or half `malu[1]` (half), then extended per `msign`. Word loads pass through unchanged.
- State machine:
  - IDLE
    - Non-memory instruction: pass through with no stall and `mmo`=0.
    - Aligned memory op: latch address, enables, write data and we; raise `mstall`; go to REQ.
    - Misaligned memory op: pulse `maddr_err`; load `mbadvaddr` ← `malu`; force `ow_wreg`=0; no stall; no request.
  - REQ
    - `dm_req`=1 and `mstall`=1; the timeout counter increments.
    - On `dm_ack`: capture the extended load data into `rdata_q` and go to DONE.
    - When the counter reaches `TIMEOUT` without an ack: set the abort flag, load `mbadvaddr`, go to DONE.
  - DONE
    - `mstall`=0; `mmo` = `rdata_q`, or 0 for stores.
    - `ow_wreg` = `mwreg`, or forced to 0 if aborted; `mbus_err` = abort flag.
    - Always go to IDLE next cycle.
- `ow_m2reg`, `ow_rn` and `ow_alu` follow the inputs combinationally in all states.
- `ow_wreg` is forced to 0 in IDLE-with-stall and in REQ. This sends a bubble into MEM/WB.
- `dm_ack` is ignored in IDLE and DONE, including stale acks after a reset.

## Timing
- Reset values:
  - state = IDLE, counter = 0, abort = 0;
  - `rdata_q` = 0, `mbadvaddr` = 0;
  - latched `dm_addr`, `dm_be`, `dm_wdata`, `dm_we` = 0;
  - `dm_req` = 0, `mbus_err` = 0, `mstall` = 0.
- Memory op occupancy is 2 + k cycles, where k = cycles from `dm_req` rising to `dm_ack` (k ≥ 1). `mstall` is high for 1 + k cycles.
- With an ack in the first REQ cycle: cycle 0 IDLE (stall), cycle 1 REQ (ack), cycle 2 DONE (result valid, no stall). MEM/WB captures the result at the end of cycle 2.
- `dm_addr`, `dm_be`, `dm_wdata` and `dm_we` are registered. They are stable for every cycle `dm_req` is high.
- Timeout: `dm_req` is high for exactly `TIMEOUT` cycles, then DONE with `mbus_err`=1 for one cycle.
- An ack arriving in the same cycle the counter reaches `TIMEOUT` wins: the access completes normally.
- Back-to-back memory ops: DONE → IDLE picks up the next instruction immediately. There is no idle gap beyond the IDLE stall cycle.
- Reset asserted in REQ: `dm_req` drops asynchronously, and the FSM returns to IDLE with no writeback.

## Test plan
- Word load, ack on the first REQ cycle: `malu`=0x100, `dm_rdata`=0xDEADBEEF → `mstall` high for 2 cycles, `dm_addr`=0x100, `dm_be`=1111; in DONE `mmo`=0xDEADBEEF and `ow_wreg`=1.
- Signed and unsigned byte loads: `malu`=0x103, `dm_rdata`=0x80123456 → `msign`=1 gives 0xFFFFFF80; `msign`=0 gives 0x00000080.
- Halfword store: `malu`=0x22, `mb`=0x0000ABCD → `dm_be`=1100, `dm_wdata`=0xABCDABCD, `dm_we`=1; in DONE `ow_wreg`=`mwreg`, `mmo`=0.
- Misaligned word load: `malu`=0x101 → `dm_req` never rises, `maddr_err`=1 for one cycle, `mbadvaddr`=0x101, `ow_wreg`=0, `mstall`=0.
- Timeout with `TIMEOUT`=4 and no ack → `dm_req` high for exactly 4 cycles, then `mbus_err`=1 and `ow_wreg`=0 for one cycle, then IDLE.
- Reset in the second REQ cycle, followed by a stale `dm_ack` → all outputs return to reset values at once, and the stale ack causes no writeback.
